// File: rtl/sample_gather.sv
// rtl/sample_gather.sv - packs a serial sample stream into LANES-wide vectors for reg_sum
// Double-buffered: a fill buffer collects samples while the output buffer holds a vector for downstream.
module sample_gather #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [WIDTH-1:0]             s_data_i,
  input  logic                         s_valid_i,
  input  logic                         s_last_i,
  output logic                         s_ready_o,
  output logic [WIDTH-1:0]             x_o [LANES-1:0],
  output logic                         x_valid_o,
  input  logic                         x_ready_i,
  output logic [$clog2(LANES+1)-1:0]   x_count_o,
  output logic [CNT_W-1:0]             grp_cnt_o
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(LANES+1);

  logic [WIDTH-1:0] fill_q [LANES-1:0];
  logic [WIDTH-1:0] fill_d [LANES-1:0];
  logic [IDX_W-1:0] idx_q;
  logic             pend_q;
  logic [CW-1:0]    pend_cnt_q;
  logic             hs, complete, slot_free, handover, transfer;
  logic [CW-1:0]    grp_len;

  // Ready depends only on the pend flag so x_ready_i never reaches s_ready_o combinationally.
  assign s_ready_o = !pend_q;
  assign hs        = s_valid_i && !pend_q;
  assign complete  = hs && (s_last_i || (idx_q == IDX_W'(LANES-1)));
  assign slot_free = !x_valid_o || x_ready_i;
  assign handover  = x_valid_o && x_ready_i;
  assign transfer  = (complete || pend_q) && slot_free;
  assign grp_len   = pend_q ? pend_cnt_q : CW'(idx_q) + CW'(1);

  // Fill contents including the sample arriving this cycle, so a completing sample transfers directly.
  always_comb begin
    fill_d = fill_q;
    if (hs) fill_d[idx_q] = s_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LANES; i++) begin
        x_o[i]    <= '0;
        fill_q[i] <= '0;
      end
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_cnt_q <= '0;
      x_valid_o  <= 1'b0;
      x_count_o  <= '0;
      grp_cnt_o  <= '0;
    end else begin
      if (handover) grp_cnt_o <= grp_cnt_o + CNT_W'(1);

      if (transfer) begin
        x_o       <= fill_d;
        x_count_o <= grp_len;
        x_valid_o <= 1'b1;
        pend_q    <= 1'b0;
        // Cleared so unwritten lanes of a short group read as zero.
        for (int i = 0; i < LANES; i++) fill_q[i] <= '0;
      end else begin
        if (handover) x_valid_o <= 1'b0;
        if (complete) begin
          pend_q     <= 1'b1;
          pend_cnt_q <= grp_len;
        end
        fill_q <= fill_d;
      end

      if (complete)  idx_q <= '0;
      else if (hs)   idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_gather.sv
// tb/tb_sample_gather.sv - cycle table plus hand sequences for sample_gather (CNT_W = 2 to exercise wrap)
module tb_sample_gather;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] x [3:0];
  logic       x_valid, x_ready;
  logic [2:0] x_count;
  logic [1:0] grp_cnt;

  int checks = 0;
  int errors = 0;

  sample_gather #(.WIDTH(8), .LANES(4), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
    .x_o(x), .x_valid_o(x_valid), .x_ready_i(x_ready),
    .x_count_o(x_count), .grp_cnt_o(grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, l;
    logic [7:0] d;
    logic       r;
    logic       sr, xv;
    logic [2:0] xc;
    logic [7:0] x0, x1, x2, x3;
    logic [1:0] g;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, l, input logic [7:0] d, input logic r,
                              input logic sr, xv, input logic [2:0] xc,
                              input logic [7:0] x0, x1, x2, x3, input logic [1:0] g);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.r = r; t.sr = sr; t.xv = xv; t.xc = xc;
    t.x0 = x0; t.x1 = x1; t.x2 = x2; t.x3 = x3; t.g = g;
    return t;
  endfunction

  task automatic chk(input string name, input logic sr, xv, input logic [2:0] xc,
                     input logic [7:0] e0, e1, e2, e3, input logic [1:0] g);
    logic [41:0] act, exp;
    act = {s_ready, x_valid, x_count, x[0], x[1], x[2], x[3], grp_cnt};
    exp = {sr, xv, xc, e0, e1, e2, e3, g};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b v=%b cnt=%0d x[0..3]=%0d,%0d,%0d,%0d grp=%0d want rdy=%b v=%b cnt=%0d x[0..3]=%0d,%0d,%0d,%0d grp=%0d",
               name, s_ready, x_valid, x_count, x[0], x[1], x[2], x[3], grp_cnt,
               sr, xv, xc, e0, e1, e2, e3, g);
    end
  endtask

  task automatic step(input logic v, l, input logic [7:0] d, input logic r);
    s_valid = v; s_last = l; s_data = d; x_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; x_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int wrap_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    // basic group
    tbl.push_back(mk(1,0,  4,1, 1,0,0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1,0,  6,1, 1,0,0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1,0,  9,1, 1,0,0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1,0,  3,1, 1,1,4,  4, 6, 9, 3, 0));
    tbl.push_back(mk(0,0,  0,1, 1,0,4,  4, 6, 9, 3, 1));
    // back-to-back stream
    tbl.push_back(mk(1,0,  9,1, 1,0,4,  4, 6, 9, 3, 1));
    tbl.push_back(mk(1,0,  5,1, 1,0,4,  4, 6, 9, 3, 1));
    tbl.push_back(mk(1,0,  2,1, 1,0,4,  4, 6, 9, 3, 1));
    tbl.push_back(mk(1,0,  2,1, 1,1,4,  9, 5, 2, 2, 1));
    tbl.push_back(mk(1,0,  2,1, 1,0,4,  9, 5, 2, 2, 2));
    tbl.push_back(mk(1,0,  3,1, 1,0,4,  9, 5, 2, 2, 2));
    tbl.push_back(mk(1,0,  9,1, 1,0,4,  9, 5, 2, 2, 2));
    tbl.push_back(mk(1,0,  7,1, 1,1,4,  2, 3, 9, 7, 2));
    tbl.push_back(mk(0,0,  0,1, 1,0,4,  2, 3, 9, 7, 3));
    // backpressure: second group pends, then refill on handover without bubble
    tbl.push_back(mk(1,0,  1,0, 1,0,4,  2, 3, 9, 7, 3));
    tbl.push_back(mk(1,0,  2,0, 1,0,4,  2, 3, 9, 7, 3));
    tbl.push_back(mk(1,0,  3,0, 1,0,4,  2, 3, 9, 7, 3));
    tbl.push_back(mk(1,0,  4,0, 1,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(1,0,  5,0, 1,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(1,0,  6,0, 1,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(1,0,  7,0, 1,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(1,0,  8,0, 0,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(0,0,  0,0, 0,1,4,  1, 2, 3, 4, 3));
    tbl.push_back(mk(1,0, 99,1, 1,1,4,  5, 6, 7, 8, 0));
    tbl.push_back(mk(0,0,  0,0, 1,1,4,  5, 6, 7, 8, 0));
    tbl.push_back(mk(0,0,  0,1, 1,0,4,  5, 6, 7, 8, 1));
    // partial flush, ignored s_last without valid, next sample in lane 0
    tbl.push_back(mk(1,0, 10,1, 1,0,4,  5, 6, 7, 8, 1));
    tbl.push_back(mk(1,1, 20,1, 1,1,2, 10,20, 0, 0, 1));
    tbl.push_back(mk(0,1,  0,1, 1,0,2, 10,20, 0, 0, 2));
    tbl.push_back(mk(1,0, 30,1, 1,0,2, 10,20, 0, 0, 2));
    tbl.push_back(mk(1,1, 40,1, 1,1,2, 30,40, 0, 0, 2));
    tbl.push_back(mk(0,0,  0,1, 1,0,2, 30,40, 0, 0, 3));
    // full group with s_last on the final lane, then single-sample group
    tbl.push_back(mk(1,0, 11,1, 1,0,2, 30,40, 0, 0, 3));
    tbl.push_back(mk(1,0, 12,1, 1,0,2, 30,40, 0, 0, 3));
    tbl.push_back(mk(1,0, 13,1, 1,0,2, 30,40, 0, 0, 3));
    tbl.push_back(mk(1,1, 14,1, 1,1,4, 11,12,13,14, 3));
    tbl.push_back(mk(0,0,  0,1, 1,0,4, 11,12,13,14, 0));
    tbl.push_back(mk(0,1,  0,1, 1,0,4, 11,12,13,14, 0));
    tbl.push_back(mk(1,1, 55,1, 1,1,1, 55, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,  0,1, 1,0,1, 55, 0, 0, 0, 1));

    do_reset();
    chk("reset", 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].r);
      chk($sformatf("row%0d", i), tbl[i].sr, tbl[i].xv, tbl[i].xc,
          tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3, tbl[i].g);
    end

    // asynchronous reset in the middle of a group
    step(1, 0, 1, 0);
    step(1, 0, 2, 0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 0, 5, 0);
    step(1, 0, 6, 0);
    step(1, 0, 7, 0);
    step(1, 0, 8, 0);
    chk("after_reset_group", 1, 1, 4, 5, 6, 7, 8, 0);

    // counter wrap with CNT_W = 2
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 8'(k + 60), 1);
      step(0, 0, 0, 1);
      chk($sformatf("wrap%0d", k), 1, 0, 1, 8'(k + 60), 0, 0, 0, 2'(wrap_seq[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
